// File: rtl/sd_data_rx.sv
`timescale 1ns / 1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sd_data_rx                                                 |
// | Description : SD 4-bit data-block receiver. Once armed by start, waits   |
// |               for the all-low start bit, collects BLOCK_BYTES payload    |
// |               bytes (high nibble first), checks a CRC16-CCITT per DAT    |
// |               line and the end bit, then pulses done.                    |
// | Ports       : clk, reset (sync, active-high)                             |
// |               sample_en      - sdio_clk rising-edge strobe                |
// |               dat_in[3:0]    - synchronised DAT lines                     |
// |               start          - arm reception of one block (IDLE only)     |
// |               byte_data[7:0] - received byte, held between pulses        |
// |               byte_valid     - one-clk qualifier for byte_data            |
// |               busy           - block in progress                          |
// |               done           - one-clk end-of-block / error pulse         |
// |               crc_error      - sticky CRC or end-bit failure              |
// |               timeout_error  - sticky start-bit timeout                   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module sd_data_rx #(
   parameter int BLOCK_BYTES   = 512,
   parameter int TIMEOUT_TICKS = 100000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       sample_en,
   input  logic [3:0] dat_in,
   input  logic       start,
   output logic [7:0] byte_data,
   output logic       byte_valid,
   output logic       busy,
   output logic       done,
   output logic       crc_error,
   output logic       timeout_error
);

   localparam int c_nibbles = 2 * BLOCK_BYTES;
   // The same counter walks the payload nibbles and the 16 CRC nibbles.
   localparam int c_cnt_w   = ($clog2(c_nibbles) > 4) ? $clog2(c_nibbles) : 4;

   localparam logic [c_cnt_w-1:0] c_last_nib = c_cnt_w'(c_nibbles - 1);
   localparam logic [c_cnt_w-1:0] c_last_crc = c_cnt_w'(15);
   localparam logic [23:0]        c_to_last  = 24'(TIMEOUT_TICKS - 1);

   localparam logic [2:0] c_st_idle   = 3'd0;
   localparam logic [2:0] c_st_wait   = 3'd1;
   localparam logic [2:0] c_st_data   = 3'd2;
   localparam logic [2:0] c_st_crc    = 3'd3;
   localparam logic [2:0] c_st_endbit = 3'd4;
   localparam logic [2:0] c_st_finish = 3'd5;

   logic [2:0]         r_state;
   logic [c_cnt_w-1:0] r_nib_cnt;
   logic [23:0]        r_to_cnt;
   logic [3:0]         r_hi_nib;
   logic [3:0]         w_line_bad;
   logic               w_arm;

   assign w_arm = (r_state == c_st_idle) && start;

   assign busy  = (r_state == c_st_wait) || (r_state == c_st_data) ||
                  (r_state == c_st_crc)  || (r_state == c_st_endbit);
   assign done  = (r_state == c_st_finish);

   // Per-line CRC generator and received-CRC shifter.
   generate
      for (genvar i = 0; i < 4; i++) begin : g_line
         logic [15:0] r_crc;
         logic [15:0] r_rx_crc;
         logic        w_fb;
         logic [15:0] w_crc_next;

         assign w_fb       = r_crc[15] ^ dat_in[i];
         assign w_crc_next = {r_crc[14:0], 1'b0} ^ (w_fb ? 16'h1021 : 16'h0000);

         always_ff @(posedge clk) begin
            if (reset || w_arm) begin
               r_crc    <= 16'h0000;
               r_rx_crc <= 16'h0000;
            end else if (sample_en && (r_state == c_st_data)) begin
               r_crc    <= w_crc_next;
            end else if (sample_en && (r_state == c_st_crc)) begin
               r_rx_crc <= {r_rx_crc[14:0], dat_in[i]};
            end
         end

         assign w_line_bad[i] = (r_crc != r_rx_crc);
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= c_st_idle;
         r_nib_cnt     <= '0;
         r_to_cnt      <= 24'd0;
         r_hi_nib      <= 4'h0;
         byte_data     <= 8'h00;
         byte_valid    <= 1'b0;
         crc_error     <= 1'b0;
         timeout_error <= 1'b0;
      end else begin
         byte_valid <= 1'b0;
         case (r_state)
            c_st_idle: begin
               if (start) begin
                  r_state       <= c_st_wait;
                  crc_error     <= 1'b0;
                  timeout_error <= 1'b0;
                  r_nib_cnt     <= '0;
                  r_to_cnt      <= 24'd0;
               end
            end
            c_st_wait: begin
               // Only an all-low bus is a start bit; a start bit on the
               // final allowed tick still wins over the timeout.
               if (sample_en) begin
                  if (dat_in == 4'b0000) begin
                     r_state <= c_st_data;
                  end else if (r_to_cnt == c_to_last) begin
                     timeout_error <= 1'b1;
                     r_state       <= c_st_finish;
                  end else begin
                     r_to_cnt <= r_to_cnt + 24'd1;
                  end
               end
            end
            c_st_data: begin
               if (sample_en) begin
                  if (!r_nib_cnt[0]) begin
                     r_hi_nib <= dat_in;
                  end else begin
                     byte_data  <= {r_hi_nib, dat_in};
                     byte_valid <= 1'b1;
                  end
                  if (r_nib_cnt == c_last_nib) begin
                     r_nib_cnt <= '0;
                     r_state   <= c_st_crc;
                  end else begin
                     r_nib_cnt <= r_nib_cnt + 1'b1;
                  end
               end
            end
            c_st_crc: begin
               if (sample_en) begin
                  if (r_nib_cnt == c_last_crc) begin
                     r_nib_cnt <= '0;
                     r_state   <= c_st_endbit;
                  end else begin
                     r_nib_cnt <= r_nib_cnt + 1'b1;
                  end
               end
            end
            c_st_endbit: begin
               if (sample_en) begin
                  crc_error <= (|w_line_bad) || (dat_in != 4'b1111);
                  r_state   <= c_st_finish;
               end
            end
            c_st_finish: begin
               r_state <= c_st_idle;
            end
            default: begin
               r_state <= c_st_idle;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
